// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single ssdram port between three requesters.
//
// Priority (highest first): video fetch (read-only), Z80 CPU, loader/DMA.
// Each access holds ram_cs_o for ACCESS_CYCLES cycles, captures read data
// on the last of them, then pulses the owner's ack for exactly one cycle.
// A starvation counter lets DMA win over the CPU after STARVE_LIMIT
// consecutive CPU grants taken while d_req was pending.
//
// Ports:
//   clock, reset_n                       system clock, async active-low reset
//   v_req/v_addr -> v_ack/v_rdata        video read port
//   c_req/c_we/c_addr/c_wdata -> c_ack/c_rdata   CPU port
//   d_req/d_we/d_addr/d_wdata -> d_ack   DMA port (no read data return)
//   ram_addr/ram_data_o/ram_cs_o/ram_oe_o/ram_we_o, ram_data_i   ssdram side
//   busy   high whenever not IDLE
//   grant  current owner: 0 none, 1 video, 2 CPU, 3 DMA
module ram_arbiter #(
  parameter int AW            = 18,
  parameter int DW            = 8,
  parameter int ACCESS_CYCLES = 4,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          v_req,
  input  logic [AW-1:0] v_addr,
  output logic          v_ack,
  output logic [DW-1:0] v_rdata,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_o,
  input  logic [DW-1:0] ram_data_i,
  output logic          ram_cs_o,
  output logic          ram_oe_o,
  output logic          ram_we_o,
  output logic          busy,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_VID  = 2'd1;
  localparam logic [1:0] G_CPU  = 2'd2;
  localparam logic [1:0] G_DMA  = 2'd3;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [3:0]    starve_q;
  logic          we_q;

  // Arbitration result for the current IDLE cycle.
  logic [1:0]    sel_d;
  logic          sel_we_d;
  logic [AW-1:0] sel_addr_d;
  logic [DW-1:0] sel_wdata_d;
  logic [3:0]    starve_d;
  logic          starve_full;

  assign starve_full = (starve_q >= 4'(STARVE_LIMIT));

  always_comb begin
    sel_d       = G_NONE;
    sel_we_d    = 1'b0;
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    starve_d    = starve_q;
    if (v_req) begin
      // Video never waits on the starvation rule and leaves the count alone,
      // except that an absent d_req still clears it.
      sel_d      = G_VID;
      sel_addr_d = v_addr;
      if (!d_req) starve_d = '0;
    end else if (d_req && starve_full) begin
      sel_d       = G_DMA;
      sel_we_d    = d_we;
      sel_addr_d  = d_addr;
      sel_wdata_d = d_wdata;
      starve_d    = '0;
    end else if (c_req) begin
      sel_d       = G_CPU;
      sel_we_d    = c_we;
      sel_addr_d  = c_addr;
      sel_wdata_d = c_wdata;
      if (!d_req)            starve_d = '0;
      else if (!starve_full) starve_d = starve_q + 4'd1;
    end else if (d_req) begin
      sel_d       = G_DMA;
      sel_we_d    = d_we;
      sel_addr_d  = d_addr;
      sel_wdata_d = d_wdata;
      starve_d    = '0;
    end else begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      we_q       <= 1'b0;
      grant      <= G_NONE;
      busy       <= 1'b0;
      ram_addr   <= '0;
      ram_data_o <= '0;
      ram_cs_o   <= 1'b0;
      ram_oe_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      v_ack      <= 1'b0;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
      v_rdata    <= '0;
      c_rdata    <= '0;
    end else begin
      v_ack <= 1'b0;
      c_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          starve_q <= starve_d;
          if (sel_d != G_NONE) begin
            grant      <= sel_d;
            we_q       <= sel_we_d;
            ram_addr   <= sel_addr_d;
            ram_data_o <= sel_wdata_d;
            ram_cs_o   <= 1'b1;
            ram_oe_o   <= ~sel_we_d;
            ram_we_o   <= sel_we_d;
            cnt_q      <= 4'(ACCESS_CYCLES - 1);
            busy       <= 1'b1;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            ram_cs_o <= 1'b0;
            ram_oe_o <= 1'b0;
            ram_we_o <= 1'b0;
            state_q  <= ACK;
            case (grant)
              G_VID: begin
                v_ack   <= 1'b1;
                v_rdata <= ram_data_i;
              end
              G_CPU: begin
                c_ack <= 1'b1;
                // A write must not disturb the last read value.
                if (!we_q) c_rdata <= ram_data_i;
              end
              G_DMA:   d_ack <= 1'b1;
              default: ;
            endcase
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          grant   <= G_NONE;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter.
// Table of isolated single accesses plus hand-written sequences for
// priority, starvation, reset mid-access and back-to-back video.
// Every ack is matched against a scoreboard queue filled when stimulus
// is driven.
module tb_ram_arbiter;
  localparam int AW = 18;
  localparam int DW = 8;
  localparam int AC = 4;
  localparam int SL = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          v_req, c_req, c_we, d_req, d_we;
  logic [AW-1:0] v_addr, c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata, ram_data_i;
  logic          v_ack, c_ack, d_ack;
  logic [DW-1:0] v_rdata, c_rdata, ram_data_o;
  logic [AW-1:0] ram_addr;
  logic          ram_cs_o, ram_oe_o, ram_we_o, busy;
  logic [1:0]    grant;

  ram_arbiter #(.AW(AW), .DW(DW), .ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset_n(reset_n),
    .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_rdata(v_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack),
    .ram_addr(ram_addr), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .ram_cs_o(ram_cs_o), .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o),
    .busy(busy), .grant(grant)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]    owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic [1:0]    owner;
    logic          we;
    logic [DW-1:0] rdata;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  logic [1:0] mon_who;
  int   n_vec = 0;
  int   n_err = 0;
  int   tag   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, tag, act, exp);
    end
  endtask

  function automatic logic ack_of(input logic [1:0] owner);
    case (owner)
      2'd1:    return v_ack;
      2'd2:    return c_ack;
      2'd3:    return d_ack;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_reqs();
    v_req = 1'b0;
    c_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] owner, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    case (owner)
      2'd1: begin v_req = 1'b1; v_addr = addr; end
      2'd2: begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; end
      2'd3: begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
      default: ;
    endcase
  endtask

  // Scoreboard monitor: one line per completed transaction.
  always @(negedge clock) begin
    if (reset_n && (v_ack || c_ack || d_ack)) begin
      check("ack_onehot", 32'(v_ack) + 32'(c_ack) + 32'(d_ack), 32'd1);
      mon_who = v_ack ? 2'd1 : (c_ack ? 2'd2 : 2'd3);
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack (step %0d): got ack from owner %0d, expected none", tag, mon_who);
      end else begin
        mon_e = sb_q.pop_front();
        check("ack_owner", 32'(mon_who), 32'(mon_e.owner));
        if (mon_who == 2'd1) check("v_rdata", 32'(v_rdata), 32'(mon_e.rdata));
        if (mon_who == 2'd2) check("c_rdata", 32'(c_rdata), 32'(mon_e.rdata));
        $display("txn: owner=%0d we=%0d v_rdata=%02h c_rdata=%02h", mon_who, mon_e.we, v_rdata, c_rdata);
      end
    end
  end

  // Isolated access: request at T, cs T+1..T+AC, ack T+AC+1, idle T+AC+2.
  task automatic run_vec(input vec_t v);
    @(negedge clock);
    set_req(v.owner, v.we, v.addr, v.wdata);
    ram_data_i = v.rd;
    sb_q.push_back('{v.owner, v.we, v.exp_rdata});
    for (int k = 1; k <= AC; k++) begin
      @(negedge clock);
      check("cs_access", 32'(ram_cs_o), 32'd1);
      check("we_access", 32'(ram_we_o), 32'(v.we));
      check("oe_access", 32'(ram_oe_o), 32'(!v.we));
      check("ram_addr", 32'(ram_addr), 32'(v.addr));
      if (v.we) check("ram_data_o", 32'(ram_data_o), 32'(v.wdata));
      check("grant_access", 32'(grant), 32'(v.owner));
      check("busy_access", 32'(busy), 32'd1);
      check("early_ack", 32'(ack_of(v.owner)), 32'd0);
    end
    @(negedge clock);
    check("ack_cycle", 32'(ack_of(v.owner)), 32'd1);
    check("cs_in_ack", 32'(ram_cs_o), 32'd0);
    check("busy_in_ack", 32'(busy), 32'd1);
    clear_reqs();
    @(negedge clock);
    check("busy_idle", 32'(busy), 32'd0);
    check("grant_idle", 32'(grant), 32'd0);
    check("ack_once", 32'(ack_of(v.owner)), 32'd0);
  endtask

  vec_t vecs[8];
  vec_t post_rst;
  logic [1:0] pat[12];

  initial begin
    int v_cyc, c_cyc, d_cyc, nv, nc, nd, ng, nacks;
    int vack_cyc[3];
    logic [1:0] prev_grant;

    // owner, we, addr, wdata, ram_data_i, expected owner rdata after ack
    vecs[0] = '{2'd2, 1'b1, 18'h01234, 8'hA5, 8'h00, 8'h00}; // CPU write
    vecs[1] = '{2'd2, 1'b0, 18'h01234, 8'h00, 8'h3C, 8'h3C}; // CPU read
    vecs[2] = '{2'd1, 1'b0, 18'h3FFFF, 8'h00, 8'h5A, 8'h5A}; // video read
    vecs[3] = '{2'd3, 1'b1, 18'h00000, 8'hFF, 8'h00, 8'h00}; // DMA write
    vecs[4] = '{2'd3, 1'b0, 18'h2AAAA, 8'h00, 8'h77, 8'h00}; // DMA read
    vecs[5] = '{2'd2, 1'b1, 18'h15555, 8'h00, 8'h99, 8'h3C}; // write keeps rdata
    vecs[6] = '{2'd1, 1'b0, 18'h00001, 8'h00, 8'h00, 8'h00}; // video read zero
    vecs[7] = '{2'd2, 1'b0, 18'h3FFFF, 8'h00, 8'hFF, 8'hFF}; // CPU read
    post_rst = '{2'd2, 1'b0, 18'h00444, 8'h00, 8'h4D, 8'h4D};
    pat = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd2};

    reset_n = 1'b0;
    clear_reqs();
    c_we = 1'b0; d_we = 1'b0;
    v_addr = '0; c_addr = '0; d_addr = '0;
    c_wdata = '0; d_wdata = '0; ram_data_i = '0;

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_v_ack", 32'(v_ack), 32'd0);
    check("rst_c_ack", 32'(c_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_cs", 32'(ram_cs_o), 32'd0);
    check("rst_oe", 32'(ram_oe_o), 32'd0);
    check("rst_we", 32'(ram_we_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_rdata", 32'(c_rdata), 32'd0);
    reset_n = 1'b1;

    // Table-driven isolated accesses.
    for (int i = 0; i < 8; i++) begin
      tag = i;
      run_vec(vecs[i]);
    end

    // All three at once: video, then CPU, then DMA.
    tag = 100;
    @(negedge clock);
    set_req(2'd1, 1'b0, 18'h00100, 8'h00);
    set_req(2'd2, 1'b0, 18'h00200, 8'h00);
    set_req(2'd3, 1'b1, 18'h00300, 8'h42);
    sb_q.push_back('{2'd1, 1'b0, 8'h11});
    sb_q.push_back('{2'd2, 1'b0, 8'h22});
    sb_q.push_back('{2'd3, 1'b1, 8'h00});
    v_cyc = 0; c_cyc = 0; d_cyc = 0; nv = 0; nc = 0; nd = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clock);
      ram_data_i = (grant == 2'd1) ? 8'h11 : (grant == 2'd2) ? 8'h22 : 8'h33;
      if (cyc == 1)  check("prio_grant_v", 32'(grant), 32'd1);
      if (cyc == 7)  check("prio_grant_c", 32'(grant), 32'd2);
      if (cyc == 13) check("prio_grant_d", 32'(grant), 32'd3);
      if (v_ack) begin v_cyc = cyc; nv++; v_req = 1'b0; end
      if (c_ack) begin c_cyc = cyc; nc++; c_req = 1'b0; end
      if (d_ack) begin d_cyc = cyc; nd++; d_req = 1'b0; end
    end
    check("prio_v_ack_cyc", 32'(v_cyc), 32'd5);
    check("prio_c_ack_cyc", 32'(c_cyc), 32'd11);
    check("prio_d_ack_cyc", 32'(d_cyc), 32'd17);
    check("prio_ack_counts", 32'(nv * 100 + nc * 10 + nd), 32'd111);

    // Starvation: CPU and DMA held high -> 4 CPU, 1 DMA, repeating.
    tag = 200;
    @(negedge clock);
    set_req(2'd2, 1'b1, 18'h00010, 8'h5C);
    set_req(2'd3, 1'b1, 18'h00020, 8'hC5);
    for (int i = 0; i < 12; i++) sb_q.push_back('{pat[i], 1'b1, 8'h22});
    ng = 0; nacks = 0; prev_grant = 2'd0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clock);
      if (grant != 2'd0 && prev_grant == 2'd0) begin
        if (ng < 12) check("starve_grant", 32'(grant), 32'(pat[ng]));
        ng++;
      end
      prev_grant = grant;
      if (c_ack || d_ack) nacks++;
      if (nacks == 12) begin
        clear_reqs();
        break;
      end
    end
    clear_reqs();
    check("starve_ack_total", 32'(nacks), 32'd12);
    repeat (2) @(negedge clock);
    check("starve_idle", 32'(busy), 32'd0);

    // Reset in the middle of an access.
    tag = 300;
    @(negedge clock);
    set_req(2'd2, 1'b0, 18'h00444, 8'h00);
    ram_data_i = 8'hEE;
    @(negedge clock);
    check("pre_rst_cs", 32'(ram_cs_o), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_cs", 32'(ram_cs_o), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_c_rdata", 32'(c_rdata), 32'd0);
    clear_reqs();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    check("postrst_idle", 32'(busy), 32'd0);
    tag = 301;
    run_vec(post_rst);

    // Back-to-back video with a waiting CPU write.
    tag = 400;
    @(negedge clock);
    set_req(2'd1, 1'b0, 18'h3F000, 8'h00);
    set_req(2'd2, 1'b1, 18'h00777, 8'h99);
    ram_data_i = 8'h66;
    for (int i = 0; i < 3; i++) sb_q.push_back('{2'd1, 1'b0, 8'h66});
    sb_q.push_back('{2'd2, 1'b1, 8'h4D});
    nv = 0; c_cyc = 0;
    vack_cyc = '{0, 0, 0};
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clock);
      if (cyc == 19) check("b2b_cpu_grant", 32'(grant), 32'd2);
      if (v_ack) begin
        if (nv < 3) vack_cyc[nv] = cyc;
        nv++;
        if (nv >= 3) v_req = 1'b0;
      end
      if (c_ack) begin c_cyc = cyc; c_req = 1'b0; end
    end
    clear_reqs();
    check("b2b_v_acks", 32'(nv), 32'd3);
    check("b2b_v_ack0", 32'(vack_cyc[0]), 32'd5);
    check("b2b_v_ack1", 32'(vack_cyc[1]), 32'd11);
    check("b2b_v_ack2", 32'(vack_cyc[2]), 32'd17);
    check("b2b_c_ack", 32'(c_cyc), 32'd23);

    repeat (2) @(negedge clock);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
